// File: rtl/kbd_event_queue_if.sv
// ============================================================================
// Module   : kbd_event_queue_if
// Brief    : PS/2 receiver side and event-consumer side signals of kbd_event_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface kbd_event_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    ps2_data;
  logic          ps2_ready;
  logic          ps2_nextdata_n;
  logic          ev_rd;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_break;
  logic [3:0]    ev_mods;
  logic [CW-1:0] ev_count;
  logic          overflow;
  logic          ovf_clr;

  modport slave (
    input  ps2_data, ps2_ready, ev_rd, ovf_clr,
    output ps2_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_mods, ev_count, overflow
  );

  modport master (
    output ps2_data, ps2_ready, ev_rd, ovf_clr,
    input  ps2_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_mods, ev_count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/kbd_event_queue.sv
// ============================================================================
// Module   : kbd_event_queue
// Brief    : PS/2 scan-code parser with modifier tracking and FWFT event FIFO.
//            Define KBD_REPEAT_FILTER_EN to suppress typematic make repeats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_event_queue #(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              clr,
  kbd_event_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 14;   // {mods[3:0], break, ext, code[7:0]}

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRE_E0   = 2'd1,
    ST_PRE_F0   = 2'd2,
    ST_PRE_E0F0 = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           nextdata_n_q, nextdata_n_d;
  logic [255:0]   held_q, held_d;
  logic [255:0]   held_e0_q, held_e0_d;
  logic           caps_q, caps_d;
  logic [EW-1:0]  mem_q [DEPTH];
  logic [EW-1:0]  mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;

  logic           consume;
  logic           ev_done;
  logic           ev_ext;
  logic           ev_brk;
  logic [7:0]     code;
  logic [3:0]     mods_new;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           full;
  logic           drop;
  logic [EW-1:0]  head;

  assign code         = bus.ps2_data;
  assign consume      = bus.ps2_ready & nextdata_n_q;
  assign nextdata_n_d = ~consume;

  // Prefix parser: E0 marks extended keys, F0 marks releases.
  always_comb begin
    state_d = state_q;
    ev_done = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (consume) begin
      case (state_q)
        ST_IDLE: begin
          if (code == 8'hE0)      state_d = ST_PRE_E0;
          else if (code == 8'hF0) state_d = ST_PRE_F0;
          else                    ev_done = 1'b1;
        end
        ST_PRE_E0: begin
          if (code == 8'hF0)      state_d = ST_PRE_E0F0;
          else if (code != 8'hE0) begin
            ev_done = 1'b1;
            ev_ext  = 1'b1;
          end
        end
        ST_PRE_F0: begin
          if (code != 8'hF0) begin
            ev_done = 1'b1;
            ev_brk  = 1'b1;
          end
        end
        default: begin
          if (code != 8'hF0) begin
            ev_done = 1'b1;
            ev_ext  = 1'b1;
            ev_brk  = 1'b1;
          end
        end
      endcase
      if (ev_done) state_d = ST_IDLE;
    end
  end

  always_comb begin
    held_d    = held_q;
    held_e0_d = held_e0_q;
    caps_d    = caps_q;
    if (ev_done) begin
      if (ev_ext) held_e0_d[code] = ~ev_brk;
      else        held_d[code]    = ~ev_brk;
      if (!ev_ext && ev_brk && code == 8'h58) caps_d = ~caps_q;
    end
  end

  // Snapshot reflects the event itself, so derive from next-state tables.
  assign mods_new = {caps_d,
                     held_d[8'h11] | held_e0_d[8'h11],
                     held_d[8'h14] | held_e0_d[8'h14],
                     held_d[8'h12] | held_d[8'h59]};

`ifdef KBD_REPEAT_FILTER_EN
  logic is_repeat;
  assign is_repeat = !ev_brk && (ev_ext ? held_e0_q[code] : held_q[code]);
  assign push_req  = ev_done & ~is_repeat;
`else
  assign push_req  = ev_done;
`endif

  assign full = (count_q == CW'(DEPTH));
  assign pop  = bus.ev_rd && (count_q != '0);
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q] = {mods_new, ev_brk, ev_ext, code};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    // A fresh drop takes priority over a clear request on the same edge.
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_IDLE;
      nextdata_n_q <= 1'b1;
      held_q       <= '0;
      held_e0_q    <= '0;
      caps_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      held_q       <= held_d;
      held_e0_q    <= held_e0_d;
      caps_q       <= caps_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign head               = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.ev_valid       = (count_q != '0);
  assign bus.ev_code        = head[7:0];
  assign bus.ev_ext         = head[8];
  assign bus.ev_break       = head[9];
  assign bus.ev_mods        = head[13:10];
  assign bus.ev_count       = count_q;
  assign bus.overflow       = overflow_q;
  assign bus.ps2_nextdata_n = nextdata_n_q;

endmodule

`default_nettype wire

// File: doc/kbd_event_queue.md
KBD_EVENT_QUEUE -- requirements
Module: kbd_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning event FIFO entries; power of two, >=2.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: clr  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: ps2_data  in  8  byte from PS/2 receiver.
REQ-005 SHALL have port: ps2_ready  in  1  receiver holds an unread byte.
REQ-006 SHALL have port: ps2_nextdata_n  out  1  active-low one-cycle pop strobe to receiver.
REQ-007 SHALL have port: ev_rd  in  1  consumer pops head event.
REQ-008 SHALL have ports: ev_valid out 1 FIFO non-empty; ev_code out 8 head scan code; ev_ext out 1 head had E0 prefix; ev_break out 1 head is release.
REQ-009 SHALL have port: ev_mods  out  4  head modifier snapshot {capslock, alt, ctrl, shift}.
REQ-010 SHALL have port: ev_count  out  clog2(DEPTH)+1  occupied entries.
REQ-011 SHALL have ports: overflow out 1 sticky drop flag; ovf_clr in 1 clears overflow.

Function
REQ-012 SHALL consume a byte on a rising edge where ps2_ready=1 and ps2_nextdata_n=1, then drive ps2_nextdata_n=0 for exactly the following cycle; no byte consumed while ps2_nextdata_n=0.
REQ-013 SHALL parse with states IDLE, PRE_E0, PRE_F0, PRE_E0F0: IDLE+E0->PRE_E0; IDLE+F0->PRE_F0; PRE_E0+F0->PRE_E0F0; PRE_E0+E0 stays PRE_E0; any other byte completes an event and returns to IDLE.
REQ-014 SHALL form event {code=byte, ext=1 if via PRE_E0/PRE_E0F0, break=1 if via PRE_F0/PRE_E0F0}; F0 received in PRE_F0 or PRE_E0F0 is ignored (state held).
REQ-015 SHALL maintain held tables held[256] (ext=0) and held_e0[256] (ext=1): make sets bit, break clears bit, on the completing edge.
REQ-016 SHALL derive shift=held[0x12]|held[0x59]; ctrl=held[0x14]|held_e0[0x14]; alt=held[0x11]|held_e0[0x11]; capslock toggles on non-ext break of 0x58.
REQ-017 SHALL store in ev_mods the modifier values after applying the event itself (shift make carries shift=1, shift break carries shift=0).
REQ-018 SHALL write completed events into the FIFO on the completing edge; ev_valid/ev_* reflect head combinationally (first-word-fall-through), so latency final-byte-consumed edge -> ev_valid=1 is one edge when empty.
REQ-019 SHALL pop head on rising edge with ev_rd=1 and ev_valid=1; ev_rd with FIFO empty has no effect.
REQ-020 SHALL, when push and pop coincide, perform both; ev_count unchanged; accepted even when full.
REQ-021 SHALL, on push with FIFO full and no pop, drop the event, set overflow=1; held tables and capslock still update.
REQ-022 SHALL keep overflow=1 until ovf_clr edge or reset; a same-edge new drop wins over ovf_clr.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; ev_count ranges 0..DEPTH.

Reset
REQ-024 SHALL on clr=1 asynchronously force: ps2_nextdata_n=1, parser IDLE, FIFO empty (ev_valid=0, ev_count=0), held tables clear, capslock=0, overflow=0.
REQ-025 SHALL discard a partial prefix sequence on reset; the next byte after release parses from IDLE.
REQ-026 SHALL present ev_code=0, ev_ext=0, ev_break=0, ev_mods=0 while empty after reset.

Configuration
REQ-027 SHALL, with KBD_REPEAT_FILTER_EN defined, not push a make event whose key is already held (typematic repeats suppressed); held/modifier state unchanged by it.
REQ-028 SHALL, without KBD_REPEAT_FILTER_EN, push every make event including typematic repeats.

Verification
REQ-029 Bytes 1C, F0, 1C -> two events {1C,ext0,brk0,mods0},{1C,ext0,brk1,mods0}; ps2_nextdata_n low one cycle per byte.
REQ-030 Bytes 12, 1C, E0, F0, 14 -> events mods=0001, 1C mods=0001, {14,ext1,brk1,mods=0001}.
REQ-031 Bytes 1C,1C,1C,F0,1C -> 4 events without KBD_REPEAT_FILTER_EN, 2 events with it.
REQ-032 DEPTH=8, 9 makes without ev_rd -> ev_count=8, overflow=1, head code = first make; ovf_clr -> overflow=0.
REQ-033 FIFO full, final byte and ev_rd same edge -> ev_count stays 8, overflow=0.
REQ-034 Byte E0 then clr pulse then 1C -> event {1C,ext0,brk0}; F0 58 twice -> capslock 1 then 0.
